hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch squash, data-memory freeze,
// EX operand forwarding selects and stall/timeout status.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_idx,
    input  logic [4:0]  id_rs2_idx,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd_idx,
    input  logic        id_reg_we,
    input  logic        id_is_load,
    input  logic        ex_jb,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        stall,
    output logic        jb,
    output logic        freeze,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } shadow_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam shadow_t BUBBLE = '0;

    state_t         r_state;
    logic [7:0]     r_wait_cnt;
    logic           r_timeout;
    shadow_t [2:0]  r_pipe;
    logic [1:0]     r_fwd1;
    logic [1:0]     r_fwd2;
    logic [15:0]    r_stall_cnt;

    shadow_t        w_e;
    shadow_t        w_id_entry;
    shadow_t        w_e_next;
    shadow_t [2:0]  w_pipe_next;
    logic           w_freeze;
    logic           w_hazard;
    logic           w_jb;
    logic           w_stall;
    logic           w_stall_f;
    logic           w_bubble;
    logic [1:0]     w_fwd1;
    logic [1:0]     w_fwd2;

    function automatic logic [1:0] fwd_sel(input logic [4:0] idx, input logic used,
                                           input shadow_t ex_ent, input shadow_t mem_ent);
        if (!used || idx == 5'd0)
            return 2'b00;
        if (ex_ent.we && ex_ent.rd == idx)
            return 2'b01;
        if (mem_ent.we && mem_ent.rd == idx)
            return 2'b10;
        return 2'b00;
    endfunction

    assign w_e = r_pipe[0];

    // Control decisions are gated by rst_n so every control output is quiet in reset.
    assign w_freeze  = rst_n & dmem_req & ~dmem_ready;
    assign w_hazard  = w_e.ld & w_e.we & (w_e.rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1_idx == w_e.rd)) |
                        (id_use_rs2 & (id_rs2_idx == w_e.rd)));
    assign w_jb      = rst_n & ex_jb & ~w_freeze;
    assign w_stall   = rst_n & w_hazard & ~ex_jb & ~w_freeze;
    assign w_stall_f = w_freeze | w_stall;
    assign w_bubble  = w_stall | w_jb | ~id_valid;

    always_comb begin
        w_id_entry    = BUBBLE;
        w_id_entry.rd = id_rd_idx;
        w_id_entry.we = id_reg_we;
        w_id_entry.ld = id_is_load;
    end

    assign w_e_next    = w_bubble ? BUBBLE : w_id_entry;
    assign w_pipe_next = w_freeze ? r_pipe : {r_pipe[1:0], w_e_next};

    assign w_fwd1 = fwd_sel(id_rs1_idx, id_use_rs1, r_pipe[0], r_pipe[1]);
    assign w_fwd2 = fwd_sel(id_rs2_idx, id_use_rs2, r_pipe[0], r_pipe[1]);

    // Shadow stages: index 0 = EX, 1 = MEM, 2 = WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= w_pipe_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd1 <= 2'b00;
            r_fwd2 <= 2'b00;
        end else if (!w_freeze) begin
            r_fwd1 <= w_bubble ? 2'b00 : w_fwd1;
            r_fwd2 <= w_bubble ? 2'b00 : w_fwd2;
        end
    end

    // Memory-wait FSM with wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (dmem_req && !dmem_ready)
                        r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        if (r_wait_cnt != 8'hFF)
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (r_wait_cnt >= 8'hFE)
                            r_timeout <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_f && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_f      = w_stall_f;
    assign stall_d      = w_stall_f;
    assign flush_d      = w_jb;
    assign stall        = w_stall;
    assign jb           = w_jb;
    assign freeze       = w_freeze;
    assign fwd_rs1_sel  = r_fwd1;
    assign fwd_rs2_sel  = r_fwd2;
    assign mem_timeout  = r_timeout;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic,
// compared each cycle against a queue-based pipeline reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1_idx = '0;
    logic [4:0]  id_rs2_idx = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [4:0]  id_rd_idx = '0;
    logic        id_reg_we = 1'b0;
    logic        id_is_load = 1'b0;
    logic        ex_jb = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b1;
    logic        stall_f, stall_d, flush_d, stall, jb, freeze;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd_idx(id_rd_idx),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .ex_jb(ex_jb), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .stall(stall),
        .jb(jb), .freeze(freeze), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: instructions in flight, front = EX, next = MEM, last = WB.
    typedef struct {
        int rd;
        bit we;
        bit ld;
    } ent_t;

    ent_t pipe[$];
    int   m_f1, m_f2;
    bit   m_wait;
    int   m_wcnt;
    bit   m_to;
    int   m_sc;

    function automatic int src_sel(input int idx, input bit used);
        if (!used || idx == 0) return 0;
        if (pipe[0].we && pipe[0].rd == idx) return 1;
        if (pipe[1].we && pipe[1].rd == idx) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        ent_t b;
        b = '{0, 0, 0};
        pipe = {};
        repeat (3) pipe.push_back(b);
        m_f1 = 0; m_f2 = 0; m_wait = 0; m_wcnt = 0; m_to = 0; m_sc = 0;
    endtask

    task automatic cycle();
        bit   frz, haz, ejb, estl, bub;
        int   nf1, nf2;
        ent_t nxt;
        @(negedge clk);
        frz  = dmem_req && !dmem_ready;
        haz  = pipe[0].ld && pipe[0].we && pipe[0].rd != 0 &&
               ((id_use_rs1 && int'(id_rs1_idx) == pipe[0].rd) ||
                (id_use_rs2 && int'(id_rs2_idx) == pipe[0].rd));
        ejb  = ex_jb && !frz;
        estl = haz && !ex_jb && !frz;
        chk("freeze", freeze, frz);
        chk("jb", jb, ejb);
        chk("flush_d", flush_d, ejb);
        chk("stall", stall, estl);
        chk("stall_f", stall_f, frz || estl);
        chk("stall_d", stall_d, frz || estl);
        chk("fwd_rs1", fwd_rs1_sel, m_f1);
        chk("fwd_rs2", fwd_rs2_sel, m_f2);
        chk("mem_timeout", mem_timeout, m_to);
        chk("stall_cycles", stall_cycles, m_sc);
        bub = estl || ejb || !id_valid;
        nxt = bub ? '{0, 0, 0} : '{int'(id_rd_idx), id_reg_we, id_is_load};
        nf1 = bub ? 0 : src_sel(int'(id_rs1_idx), id_use_rs1);
        nf2 = bub ? 0 : src_sel(int'(id_rs2_idx), id_use_rs2);
        @(posedge clk);
        if (!frz) begin
            pipe.push_front(nxt);
            void'(pipe.pop_back());
            m_f1 = nf1;
            m_f2 = nf2;
        end
        if (!m_wait) begin
            if (frz) m_wait = 1;
        end else if (dmem_ready) begin
            m_wait = 0;
            m_wcnt = 0;
        end else begin
            if (m_wcnt < 255) m_wcnt++;
            if (m_wcnt == 255) m_to = 1;
        end
        if ((frz || estl) && m_sc < 65535) m_sc++;
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we, input bit ld);
        id_valid = v;
        id_rs1_idx = rs1[4:0]; id_use_rs1 = u1;
        id_rs2_idx = rs2[4:0]; id_use_rs2 = u2;
        id_rd_idx = rd[4:0]; id_reg_we = we; id_is_load = ld;
    endtask

    // Drives hostile control inputs while reset is held; outputs must stay quiet.
    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        ex_jb = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("rst_async_freeze", freeze, 0);
        chk("rst_async_timeout", mem_timeout, 0);
        chk("rst_async_jb", jb, 0);
        chk("rst_async_stall_f", stall_f, 0);
        chk("rst_async_cnt", stall_cycles, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush_d", flush_d, 0);
        chk("rst_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 0);
        ex_jb = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // lw x5 ; add x6,x5,x7
        set_id(1, 1, 1, 0, 0, 5, 1, 1); cycle();
        set_id(1, 5, 1, 7, 1, 6, 1, 0);
        #1 chk("lu_stall", stall, 1);
        cycle();
        chk("lu_cnt", stall_cycles, 1);
        cycle();
        chk("lu_fwd_wb", fwd_rs1_sel, 2);
        set_id(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        chk("lu_cnt_once", stall_cycles, 1);

        // add x5 ; sub x8,x5,x5 and with one instruction between
        do_reset();
        set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle();
        set_id(1, 5, 1, 5, 1, 8, 1, 0); cycle();
        chk("fwd_mem_pair", {fwd_rs1_sel, fwd_rs2_sel}, 4'b0101);
        set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle();
        set_id(1, 3, 1, 4, 1, 9, 1, 0); cycle();
        set_id(1, 5, 1, 5, 1, 8, 1, 0); cycle();
        chk("fwd_wb_pair", {fwd_rs1_sel, fwd_rs2_sel}, 4'b1010);
        chk("alu_nostall", stall_cycles, 0);

        // jb coincident with load-use
        do_reset();
        set_id(1, 1, 1, 0, 0, 5, 1, 1); cycle();
        set_id(1, 5, 1, 0, 0, 6, 1, 0); ex_jb = 1'b1;
        #1 chk("jb_over_lu", {jb, flush_d, stall}, 3'b110);
        cycle();
        ex_jb = 1'b0;
        #1 chk("jb_bubble_nostall", stall, 0);
        cycle();
        chk("jb_bubble_fwd", fwd_rs1_sel, 2);

        // x0 never stalls or forwards
        set_id(1, 1, 1, 0, 0, 0, 1, 1); cycle();
        set_id(1, 0, 1, 0, 1, 7, 1, 0);
        #1 chk("x0_nostall", stall, 0);
        cycle();
        chk("x0_nofwd", {fwd_rs1_sel, fwd_rs2_sel}, 0);

        // freeze with held ex_jb, then release
        do_reset();
        ex_jb = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_hold", {freeze, jb, stall_f}, 3'b101);
            cycle();
        end
        dmem_ready = 1'b1;
        #1 chk("frz_release_jb", {freeze, jb}, 2'b01);
        cycle();
        ex_jb = 1'b0; dmem_req = 1'b0;
        cycle();

        // long wait: timeout, then async reset mid-wait
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 250) chk("to_not_yet", mem_timeout, 0);
            cycle();
        end
        chk("to_set", mem_timeout, 1);
        do_reset();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            set_id($urandom_range(9) != 0, $urandom_range(3), $urandom_range(1),
                   $urandom_range(3), $urandom_range(1), $urandom_range(3),
                   $urandom_range(1), $urandom_range(2) == 0);
            ex_jb      = ($urandom_range(9) == 0);
            dmem_req   = ($urandom_range(2) == 0);
            dmem_ready = ($urandom_range(4) < 3);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
